// File: rtl/mmio_controller.sv
// mmio_controller
//   MEM-stage data memory and MMIO controller for the five-stage RV32I core.
//   It decodes byte, halfword and word loads and stores to these targets:
//     - on-chip RAM (read-first, one cycle of latency)
//     - a buffered UART transmitter (8N1 framing, TX FIFO)
//     - a UART status register
//     - a free-running cycle counter
//   Load data comes back aligned and sign- or zero-extended one cycle after the
//   request.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous, active-high
//   is_store    store request this cycle
//   is_load     load request this cycle
//   is_flash_e  pipeline flush; this cycle's request has no side effects
//   mem_wren    funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ram_addr    byte address
//   w_data      store data, right-aligned
//   r_data      load result, valid the cycle after the load request
//   stall       combinational; high while a UART store is blocked by a full FIFO
//   misaligned  one-cycle registered pulse after a misaligned access
//   counter     current cycle count
//   uart_tx     serial output, idle high
module mmio_controller #(
  parameter logic [31:0] RAM_BASE     = 32'h0000_6100,
  parameter int          RAM_WORDS    = 2048,
  parameter logic [31:0] UART_ADDR    = 32'h0000_F000,
  parameter logic [31:0] UART_STAT    = 32'h0000_F004,
  parameter logic [31:0] CNT_ADDR     = 32'h0000_F008,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 234
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_store,
  input  logic        is_load,
  input  logic        is_flash_e,
  input  logic [2:0]  mem_wren,
  input  logic [31:0] ram_addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        stall,
  output logic        misaligned,
  output logic [31:0] counter,
  output logic        uart_tx
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam int          CLK_W     = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_REG} src_t;

  // ---------------------------------------------------------------------------
  // Address decode and access qualification
  // ---------------------------------------------------------------------------
  logic [31:0]       ram_off;
  logic              hit_ram, hit_uart, hit_stat, hit_cnt;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        byte_off;
  logic              misalign_c;
  logic              request;
  logic              access_ok;
  logic              fifo_empty, fifo_full;
  logic              tx_pop, tx_busy;

  assign ram_off  = ram_addr - RAM_BASE;
  assign hit_ram  = (ram_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
  assign hit_uart = (ram_addr == UART_ADDR);
  assign hit_stat = (ram_addr == UART_STAT);
  assign hit_cnt  = (ram_addr == CNT_ADDR);
  assign ram_idx  = ram_off[RAM_AW+1:2];
  assign byte_off = ram_addr[1:0];

  // Halfwords need even addresses; words need 4-byte alignment.
  assign misalign_c = ((mem_wren[1:0] == 2'b01) && ram_addr[0]) ||
                      ((mem_wren == 3'b010) && (ram_addr[1:0] != 2'b00));

  // A pop in the same cycle frees a slot, so a full FIFO only stalls a UART store
  // when the transmitter is not pulling a byte out right now.
  assign stall = is_store && !is_flash_e && hit_uart && fifo_full && !tx_pop;

  assign request   = (is_load || is_store) && !is_flash_e && !stall;
  assign access_ok = request && !misalign_c;

  always_ff @(posedge clk) begin
    if (reset) misaligned <= 1'b0;
    else       misaligned <= request && misalign_c;
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= 32'd0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign counter = cycle_cnt;

  // ---------------------------------------------------------------------------
  // RAM: byte-lane writes, read-first registered read
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [RAM_WORDS];
  logic [31:0] ram_rdata_q;
  logic [3:0]  ram_be;
  logic [31:0] wdata_sh;
  logic        ram_we, ram_re;

  always_comb begin
    ram_be = 4'b1111;
    case (mem_wren[1:0])
      2'b00:   ram_be = 4'b0001 << byte_off;
      2'b01:   ram_be = 4'b0011 << byte_off;
      default: ram_be = 4'b1111;
    endcase
  end

  assign wdata_sh = w_data << {byte_off, 3'b000};
  assign ram_we   = access_ok && is_store && hit_ram;
  assign ram_re   = access_ok && is_load && hit_ram;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram_mem[ram_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
    if (ram_re) ram_rdata_q <= ram_mem[ram_idx];
  end

  // ---------------------------------------------------------------------------
  // UART TX FIFO (pointers carry an extra wrap bit)
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_push  = access_ok && is_store && hit_uart && (mem_wren == 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= w_data[7:0];
  end

  // ---------------------------------------------------------------------------
  // Load pipeline: capture source, offset and width with the request
  // ---------------------------------------------------------------------------
  logic [31:0] stat_word;
  src_t        ld_src_q;
  logic [1:0]  ld_off_q;
  logic [2:0]  ld_f3_q;
  logic [31:0] reg_word_q;

  assign stat_word = {16'h0000, 8'(fifo_count), 5'b00000, tx_busy, fifo_full, fifo_empty};

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_src_q   <= SRC_NONE;
      ld_off_q   <= 2'b00;
      ld_f3_q    <= 3'b000;
      reg_word_q <= 32'd0;
    end else if (access_ok && is_load) begin
      ld_off_q <= byte_off;
      ld_f3_q  <= mem_wren;
      if (hit_ram) begin
        ld_src_q <= SRC_RAM;
      end else if (hit_stat) begin
        ld_src_q   <= SRC_REG;
        reg_word_q <= stat_word;
      end else if (hit_cnt) begin
        ld_src_q   <= SRC_REG;
        reg_word_q <= cycle_cnt;
      end else begin
        ld_src_q <= SRC_NONE;
      end
    end
  end

  // Align the selected word and extend it according to the captured funct3.
  logic [31:0] src_word, src_sh;

  always_comb begin
    src_word = 32'd0;
    case (ld_src_q)
      SRC_RAM: src_word = ram_rdata_q;
      SRC_REG: src_word = reg_word_q;
      default: src_word = 32'd0;
    endcase
    src_sh = src_word >> {ld_off_q, 3'b000};
    r_data = src_sh;
    case (ld_f3_q)
      3'b000:  r_data = {{24{src_sh[7]}}, src_sh[7:0]};
      3'b001:  r_data = {{16{src_sh[15]}}, src_sh[15:0]};
      3'b100:  r_data = {24'h000000, src_sh[7:0]};
      3'b101:  r_data = {16'h0000, src_sh[15:0]};
      default: r_data = src_sh;
    endcase
  end

  // ---------------------------------------------------------------------------
  // UART TX FSM
  // ---------------------------------------------------------------------------
  tx_state_t        tx_state, tx_next;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_shift;
  logic             tick;

  assign tick = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // Next-state logic; STOP goes straight to START when another byte is waiting
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty)              tx_next = TX_START;
      TX_START: if (tick)                     tx_next = TX_DATA;
      TX_DATA:  if (tick && bit_idx == 3'd7)  tx_next = TX_STOP;
      TX_STOP:  if (tick)                     tx_next = fifo_empty ? TX_IDLE : TX_START;
      default:                                tx_next = TX_IDLE;
    endcase
  end

  // Output logic: line level, FIFO pop strobe, busy flag
  always_comb begin
    uart_tx = 1'b1;
    tx_pop  = 1'b0;
    tx_busy = (tx_state != TX_IDLE);
    case (tx_state)
      TX_IDLE:  tx_pop  = !fifo_empty;
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift[0];
      TX_STOP:  tx_pop  = tick && !fifo_empty;
      default:  uart_tx = 1'b1;
    endcase
  end

  // Bit timing, bit index and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
      tx_shift <= 8'hFF;
    end else begin
      if (tx_state == TX_IDLE || tick) clk_cnt <= '0;
      else                             clk_cnt <= clk_cnt + CLK_W'(1);

      if (tx_state != TX_DATA)  bit_idx <= 3'd0;
      else if (tick)            bit_idx <= bit_idx + 3'd1;

      if (tx_pop)                          tx_shift <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
      else if (tx_state == TX_DATA && tick) tx_shift <= {1'b1, tx_shift[7:1]};
    end
  end

endmodule
